io_bus_arbiter: RTL and testbench
=================================

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: address width of master and device bus.
REQ-002 Parameter DATA_W, default 16: data width of master and device bus.
REQ-003 Parameter WAIT_CYC, default 0: extra device enable cycles per access, 0..15.
REQ-004 Port clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port m_req  input  4  per-master transaction request; held high until m_done.
REQ-007 Port m_ctrl  input  4  per-master direction; 1 = IO_CTRL_WRITE, 0 = IO_CTRL_READ.
REQ-008 Port m_addr  input  4*ADDR_W  per-master address, master i at bits [i*ADDR_W +: ADDR_W].
REQ-009 Port m_wdata  input  4*DATA_W  per-master write data, same packing.
REQ-010 Port m_gnt  output  4  one-hot grant; identifies the owner of the current transaction.
REQ-011 Port m_done  output  4  one-cycle completion pulse to the owner.
REQ-012 Port m_err  output  1  valid with m_done; 1 = unmapped address.
REQ-013 Port m_rdata  output  DATA_W  read data, valid with m_done.
REQ-014 Port bus_addr  output  ADDR_W  device bus address.
REQ-015 Port bus_ctrl  output  1  device bus direction, same encoding as m_ctrl.
REQ-016 Port bus_wdata  output  DATA_W  device bus write data.
REQ-017 Port bus_rdata  input  DATA_W  device bus read data, merged from device tristate outputs.
REQ-018 Port dev_en  output  8  per-device bus grant (EN), one-hot or zero.

Function
REQ-019 Device select: dev_en index = bus_addr[ADDR_W-1 -: 4]; values 0..7 mapped, 8..15 unmapped.
REQ-020 FSM states: IDLE, SETUP, ACCESS, RESP.
REQ-021 IDLE: if any m_req, latch winner index, its ctrl/addr/wdata, set m_gnt, go SETUP; else stay.
REQ-022 Arbitration: round-robin; search starts at rr_ptr, ascending, wrapping 3->0.
REQ-023 rr_ptr updates to (winner+1) mod 4 on entry to RESP; reset value 0.
REQ-024 SETUP: bus_addr/bus_ctrl/bus_wdata driven from latched values, dev_en all 0, one cycle.
REQ-025 SETUP exit: go ACCESS if mapped; go RESP with err=1 if unmapped.
REQ-026 ACCESS: dev_en[sel] high for exactly WAIT_CYC+1 cycles, tracked by a 4-bit counter.
REQ-027 Read: m_rdata captured from bus_rdata on the last ACCESS cycle; write: m_rdata captured as 0.
REQ-028 RESP: m_done[winner] high one cycle, m_err valid; next state IDLE; m_gnt cleared on exit.
REQ-029 Latency: req sampled in IDLE at edge N -> m_done high in cycle N+3+WAIT_CYC.
REQ-030 Bus fields remain stable from SETUP through the end of ACCESS.
REQ-031 Request dropped mid-transaction: transaction still completes, m_done still pulses.
REQ-032 Owner re-requesting in RESP is not considered until IDLE; back-to-back same master gap = 1 IDLE cycle.
REQ-033 Unmapped access: no dev_en pulse, m_rdata = 0, m_err = 1.
REQ-034 Only one transaction in flight; m_gnt popcount <= 1, dev_en popcount <= 1 at all times.

Reset
REQ-035 rst high at an edge: state IDLE, rr_ptr 0, m_gnt 0, m_done 0, m_err 0, m_rdata 0, dev_en 0, bus_addr 0, bus_ctrl 0 (read), bus_wdata 0.
REQ-036 Reset mid-transaction aborts it: no m_done issued, dev_en low next cycle.

Verification
REQ-037 WAIT_CYC=0, master 0 reads 0x1004, bus_rdata=0xA5A5 -> dev_en[1] high 1 cycle, m_done[0] at N+3, m_rdata=0xA5A5, m_err=0.
REQ-038 WAIT_CYC=2, master 2 writes 0x3000<-0x1234 -> dev_en[3] high 3 cycles, bus_ctrl=1, bus_wdata=0x1234, m_done[2] at N+5.
REQ-039 All four m_req high from reset, held -> grant order 0,1,2,3,0; each m_done 4 cycles apart.
REQ-040 Master 1 reads 0x9000 -> no dev_en, m_done[1] at N+2 with m_err=1, m_rdata=0.
REQ-041 rst asserted during ACCESS -> next cycle all outputs at reset values, no m_done; later request served from master 0 priority.
REQ-042 Master 3 drops m_req in SETUP -> ACCESS and m_done[3] still occur; m_gnt returns to 0 after RESP.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter: four masters share one device bus of eight devices with fixed SETUP/ACCESS/RESP phases.
// Request to m_done takes 3+WAIT_CYC cycles (2 if unmapped); masters hold m_req, one transaction in flight at a time.
module io_bus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            m_req,
  input  logic [3:0]            m_ctrl,
  input  logic [4*ADDR_W-1:0]   m_addr,
  input  logic [4*DATA_W-1:0]   m_wdata,
  output logic [3:0]            m_gnt,
  output logic [3:0]            m_done,
  output logic                  m_err,
  output logic [DATA_W-1:0]     m_rdata,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_ctrl,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic [7:0]            dev_en
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_rr_ptr;
  logic [1:0]          r_owner;
  logic [3:0]          r_wait;
  logic [3:0]          r_gnt;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic                r_bus_ctrl;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic                w_win_vld;
  logic [1:0]          w_win_idx;
  logic [1:0]          w_cand;
  logic [3:0]          w_sel;
  logic                w_mapped;
  logic                w_last;

  assign w_sel    = r_bus_addr[ADDR_W-1 -: 4];
  assign w_mapped = ~w_sel[3];
  assign w_last   = (r_wait == 4'(WAIT_CYC));

  // Scan from the highest offset down so the candidate nearest r_rr_ptr wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = r_rr_ptr;
    w_cand    = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_rr_ptr + 2'(k);
      if (m_req[w_cand]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    m_done = 4'b0;
    dev_en = 8'b0;
    case (r_state)
      IDLE:   if (w_win_vld) w_next = SETUP;
      SETUP:  w_next = w_mapped ? ACCESS : RESP;
      ACCESS: begin
        dev_en = 8'b1 << w_sel[2:0];
        if (w_last) w_next = RESP;
      end
      RESP: begin
        m_done = r_gnt;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= 2'd0;
      r_owner     <= 2'd0;
      r_wait      <= 4'd0;
      r_gnt       <= 4'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_bus_addr  <= '0;
      r_bus_ctrl  <= 1'b0;
      r_bus_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_win_vld) begin
          r_owner     <= w_win_idx;
          r_gnt       <= 4'b1 << w_win_idx;
          r_bus_addr  <= m_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
          r_bus_ctrl  <= m_ctrl[w_win_idx];
          r_bus_wdata <= m_wdata[int'(w_win_idx)*DATA_W +: DATA_W];
        end
        SETUP: begin
          r_wait <= 4'd0;
          r_err  <= ~w_mapped;
          if (!w_mapped) begin
            r_rdata  <= '0;
            r_rr_ptr <= r_owner + 2'd1;
          end
        end
        ACCESS: begin
          r_wait <= r_wait + 4'd1;
          if (w_last) begin
            r_rdata  <= r_bus_ctrl ? '0 : bus_rdata;
            r_rr_ptr <= r_owner + 2'd1;
          end
        end
        RESP: r_gnt <= 4'b0;
        default: ;
      endcase
    end
  end

  assign m_gnt     = r_gnt;
  assign m_err     = r_err;
  assign m_rdata   = r_rdata;
  assign bus_addr  = r_bus_addr;
  assign bus_ctrl  = r_bus_ctrl;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: one instance with WAIT_CYC=0, one with WAIT_CYC=2.
module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req0, req2, ctrl;
  logic [63:0] addr, wdata;
  logic [15:0] rdata;
  logic        use2;

  logic [3:0]  gnt0, done0, gnt2, done2;
  logic        err0, err2, bc0, bc2;
  logic [15:0] rd0, rd2, ba0, ba2, bw0, bw2;
  logic [7:0]  de0, de2;

  logic [3:0]  v_gnt, v_done;
  logic        v_err, v_bc;
  logic [15:0] v_rd, v_ba, v_bw;
  logic [7:0]  v_de;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(0)) u0 (
    .clk(clk), .rst(rst), .m_req(req0), .m_ctrl(ctrl), .m_addr(addr), .m_wdata(wdata),
    .m_gnt(gnt0), .m_done(done0), .m_err(err0), .m_rdata(rd0),
    .bus_addr(ba0), .bus_ctrl(bc0), .bus_wdata(bw0), .bus_rdata(rdata), .dev_en(de0));

  io_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(2)) u2 (
    .clk(clk), .rst(rst), .m_req(req2), .m_ctrl(ctrl), .m_addr(addr), .m_wdata(wdata),
    .m_gnt(gnt2), .m_done(done2), .m_err(err2), .m_rdata(rd2),
    .bus_addr(ba2), .bus_ctrl(bc2), .bus_wdata(bw2), .bus_rdata(rdata), .dev_en(de2));

  assign v_gnt  = use2 ? gnt2  : gnt0;
  assign v_done = use2 ? done2 : done0;
  assign v_err  = use2 ? err2  : err0;
  assign v_rd   = use2 ? rd2   : rd0;
  assign v_ba   = use2 ? ba2   : ba0;
  assign v_bc   = use2 ? bc2   : bc0;
  assign v_bw   = use2 ? bw2   : bw0;
  assign v_de   = use2 ? de2   : de0;

  typedef struct {
    bit          use2;
    int          m;
    bit          ctrl;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          drop_k;     // cycle after edge N at which m_req drops; 0 = hold until m_done
    int          exp_dev;    // -1 = no device enabled
    int          exp_devcyc;
    bit          exp_err;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit sel2, input int m, input bit val);
    if (sel2) req2[m] = val;
    else      req0[m] = val;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 4'b0;
    req2 = 4'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",   {28'b0, gnt0},  32'h0);
    check("rst_done",  {28'b0, done0}, 32'h0);
    check("rst_err",   {31'b0, err0},  32'h0);
    check("rst_rdata", {16'b0, rd0},   32'h0);
    check("rst_dev_en",{24'b0, de0},   32'h0);
    check("rst_bus",   {15'b0, bc0, ba0} | {16'b0, bw0}, 32'h0);
    rst = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int k, lat, devcyc, dev;
    bit stable, gnt_ok;
    logic [3:0]  done_vec;
    logic        err_s;
    logic [15:0] rd_s;
    use2 = v.use2;
    ctrl[v.m] = v.ctrl;
    addr[v.m*16 +: 16]  = v.addr;
    wdata[v.m*16 +: 16] = v.wdata;
    rdata = v.rdata;
    set_req(v.use2, v.m, 1'b1);
    @(posedge clk);
    k = 0; lat = 0; devcyc = 0; dev = -1; stable = 1'b1; gnt_ok = 1'b1;
    done_vec = 4'b0; err_s = 1'bx; rd_s = 16'hxxxx;
    while (k < 40 && lat == 0) begin
      @(negedge clk);
      k++;
      if (v_de != 8'b0) begin
        devcyc++;
        for (int i = 0; i < 8; i++) if (v_de[i]) dev = i;
        if (v_ba !== v.addr || v_bc !== v.ctrl || v_bw !== v.wdata) stable = 1'b0;
      end
      if ($countones(v_de) > 1) stable = 1'b0;
      if (v_gnt !== (4'b1 << v.m)) gnt_ok = 1'b0;
      if (k == v.drop_k) set_req(v.use2, v.m, 1'b0);
      if (v_done != 4'b0) begin
        lat = k; done_vec = v_done; err_s = v_err; rd_s = v_rd;
        set_req(v.use2, v.m, 1'b0);
      end
    end
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_done_vec"}, {28'b0, done_vec}, {28'b0, 4'b1 << v.m});
    check({tag, "_err"}, {31'b0, err_s}, {31'b0, v.exp_err});
    check({tag, "_rdata"}, {16'b0, rd_s}, {16'b0, v.exp_rd});
    check({tag, "_dev_idx"}, dev, v.exp_dev);
    check({tag, "_dev_cycles"}, devcyc, v.exp_devcyc);
    check({tag, "_bus_stable"}, {31'b0, stable}, 32'h1);
    check({tag, "_gnt_held"}, {31'b0, gnt_ok}, 32'h1);
    @(negedge clk);
    check({tag, "_gnt_clear"}, {28'b0, v_gnt}, 32'h0);
    check({tag, "_done_once"}, {28'b0, v_done}, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k, n;
    int order[5];
    int stamp[5];
    int exp_order[5];
    bit seen;
    vec_t pre;
    rst = 1'b1; req0 = 4'b0; req2 = 4'b0; ctrl = 4'b0;
    addr = '0; wdata = '0; rdata = '0; use2 = 1'b0;

    //          use2 m  ctrl addr      wdata     rdata    drop dev cyc err rd        lat
    vecs[0] = '{1'b0, 0, 1'b0, 16'h1004, 16'h0000, 16'hA5A5, 0,  1, 1, 1'b0, 16'hA5A5, 3};
    vecs[1] = '{1'b0, 1, 1'b0, 16'h9000, 16'h0000, 16'h1111, 0, -1, 0, 1'b1, 16'h0000, 2};
    vecs[2] = '{1'b0, 3, 1'b0, 16'h5000, 16'h0000, 16'h0F0F, 1,  5, 1, 1'b0, 16'h0F0F, 3};
    vecs[3] = '{1'b0, 0, 1'b1, 16'h7FFE, 16'hBEEF, 16'h2222, 0,  7, 1, 1'b0, 16'h0000, 3};
    vecs[4] = '{1'b1, 2, 1'b1, 16'h3000, 16'h1234, 16'hFFFF, 0,  3, 3, 1'b0, 16'h0000, 5};
    vecs[5] = '{1'b1, 1, 1'b0, 16'h0000, 16'h0000, 16'h5A5A, 0,  0, 3, 1'b0, 16'h5A5A, 5};
    vecs[6] = '{1'b1, 2, 1'b0, 16'h8000, 16'h0000, 16'h3333, 0, -1, 0, 1'b1, 16'h0000, 2};

    do_reset();
    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // All four masters requesting continuously from reset.
    do_reset();
    use2 = 1'b0;
    ctrl = 4'b0;
    addr = {16'h3000, 16'h2000, 16'h1000, 16'h0000};
    req0 = 4'hF;
    n = 0; k = 0;
    exp_order = '{0, 1, 2, 3, 0};
    while (n < 5 && k < 80) begin
      @(negedge clk);
      k++;
      if (done0 != 4'b0) begin
        for (int i = 0; i < 4; i++) if (done0[i]) order[n] = i;
        stamp[n] = k;
        n++;
      end
    end
    req0 = 4'b0;
    check("rr_count", n, 5);
    for (int i = 0; i < 5; i++) if (i < n) begin
      check($sformatf("rr_order%0d", i), order[i], exp_order[i]);
      if (i > 0) check($sformatf("rr_gap%0d", i), stamp[i] - stamp[i-1], 4);
    end
    repeat (6) @(negedge clk);

    // Reset during ACCESS aborts the transaction and restores priority to master 0.
    do_reset();
    pre = '{1'b0, 1, 1'b0, 16'h1004, 16'h0000, 16'h4444, 0, 1, 1, 1'b0, 16'h4444, 3};
    run_txn(pre, "pre_abort");
    addr[2*16 +: 16] = 16'h2000;
    req0[2] = 1'b1;
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (de0 != 8'b0) seen = 1'b1;
    end
    check("abort_reach_access", {31'b0, seen}, 32'h1);
    rst = 1'b1;
    req0 = 4'b0;
    @(negedge clk);
    check("abort_done",   {28'b0, done0}, 32'h0);
    check("abort_dev_en", {24'b0, de0},   32'h0);
    check("abort_gnt",    {28'b0, gnt0},  32'h0);
    check("abort_outs",   {15'b0, err0, rd0} | {16'b0, ba0}, 32'h0);
    rst = 1'b0;
    addr[1*16 +: 16] = 16'h1004;
    addr[3*16 +: 16] = 16'h3000;
    req0 = 4'b1010;
    @(negedge clk);
    check("post_abort_gnt", {28'b0, gnt0}, 32'h2);
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (done0 != 4'b0) begin
        seen = 1'b1;
        check("post_abort_done", {28'b0, done0}, 32'h2);
      end
    end
    check("post_abort_done_seen", {31'b0, seen}, 32'h1);
    req0 = 4'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
